// File: rtl/lsb_fwd_queue_pkg.sv
// Shared types for the load/store forwarding queue: opcodes, tag type, entry layout.
package lsb_pkg;

  localparam int          OP_W        = 4;
  localparam int          LSB_ROB_W   = 4;
  localparam logic [31:0] IO_ADDR_DEF = 32'h0003_0000;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LH  = 4'd2,
    OP_LW  = 4'd3,
    OP_LBU = 4'd4,
    OP_LHU = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } op_e;

  // Tag width of the stored entries; the top-level ROB_W must match it.
  typedef logic [LSB_ROB_W-1:0] rob_t;
  localparam rob_t ZERO_ROB = '0;

  typedef struct packed {
    logic        busy;
    op_e         op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    rob_t        q1;
    rob_t        q2;
    rob_t        rob_id;
    logic        committed;
    logic        done;
  } entry_t;

  function automatic logic is_load(input op_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_word(input op_e op);
    return op inside {OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/lsb_fwd_queue_cdb_match.sv
// Tag matcher over NUM_CDB result buses; combinational, lowest channel wins on multiple hits.
module cdb_match #(
  parameter int NUM_CDB = 3,
  parameter int ROB_W   = 4
) (
  input  logic [ROB_W-1:0]         tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  output logic                     hit,
  output logic [31:0]              value
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    // Scan downwards so the lowest matching channel is written last.
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (tag != '0) && (cdb_rob_id[i*ROB_W +: ROB_W] == tag)) begin
        hit   = 1'b1;
        value = cdb_value[i*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/lsb_fwd_queue.sv
// In-order load/store queue with CDB snooping, IO ordering and a two-entry issue window.
// ex/fwd outputs are registered one-cycle pulses; full_to_if is the only backpressure.
module lsb_fwd_queue
  import lsb_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          IDX_W     = $clog2(DEPTH),
  parameter int          ROB_W     = LSB_ROB_W,
  parameter int          NUM_CDB   = 3,
  parameter int          FULL_WARN = 2,
  parameter logic [31:0] IO_ADDR   = IO_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     dsp_ena,
  input  op_e                      dsp_op,
  input  logic [31:0]              dsp_v1,
  input  logic [31:0]              dsp_v2,
  input  logic [31:0]              dsp_imm,
  input  logic [ROB_W-1:0]         dsp_q1,
  input  logic [ROB_W-1:0]         dsp_q2,
  input  logic [ROB_W-1:0]         dsp_rob_id,
  output logic                     full_to_if,
  output logic                     ex_ena,
  output op_e                      ex_op,
  output logic [31:0]              ex_addr,
  output logic [31:0]              ex_data,
  output logic [ROB_W-1:0]         ex_rob_id,
  input  logic                     ex_busy,
  output logic                     fwd_valid,
  output logic [ROB_W-1:0]         fwd_rob_id,
  output logic [31:0]              fwd_value,
  input  logic                     commit_flag,
  input  logic [ROB_W-1:0]         commit_rob_id,
  input  logic [ROB_W-1:0]         head_io_rob_id,
  output logic [ROB_W-1:0]         io_rob_id,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  input  logic                     rollback
);

  entry_t           ent [DEPTH];
  logic [IDX_W-1:0] head, tail, head_nxt, store_tail, rb_span, cm_idx;
  logic             store_tail_vld;
  logic [IDX_W:0]   count;

  logic             d1_hit, d2_hit;
  logic [31:0]      d1_val, d2_val;
  logic [DEPTH-1:0] s1_hit, s2_hit;
  logic [31:0]      s1_val [DEPTH];
  logic [31:0]      s2_val [DEPTH];
  entry_t           ins;

  logic [31:0] h_addr, l_addr;
  logic        h_rdy, l_rdy, head_free, head_ld, head_st, head_act;
  logic        win, win_byp, win_fwd, cm_hit, cm_is_store;

  cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_dsp_q1 (
    .tag(dsp_q1), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .hit(d1_hit), .value(d1_val));
  cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_dsp_q2 (
    .tag(dsp_q2), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .hit(d2_hit), .value(d2_val));

  for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
    cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_q1 (
      .tag(ent[g].q1), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .hit(s1_hit[g]), .value(s1_val[g]));
    cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_q2 (
      .tag(ent[g].q2), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .hit(s2_hit[g]), .value(s2_val[g]));
  end

  always_comb begin
    ins        = '0;
    ins.busy   = 1'b1;
    ins.op     = dsp_op;
    ins.v1     = d1_hit ? d1_val : dsp_v1;
    ins.q1     = d1_hit ? ZERO_ROB : dsp_q1;
    ins.v2     = d2_hit ? d2_val : dsp_v2;
    ins.q2     = d2_hit ? ZERO_ROB : dsp_q2;
    ins.imm    = dsp_imm;
    ins.rob_id = dsp_rob_id;
  end

  assign head_nxt = head + IDX_W'(1);
  assign rb_span  = store_tail - head;
  assign h_addr   = ent[head].v1 + ent[head].imm;
  assign l_addr   = ent[head_nxt].v1 + ent[head_nxt].imm;
  assign h_rdy    = (ent[head].q1 == ZERO_ROB) && (ent[head].q2 == ZERO_ROB);
  assign l_rdy    = (ent[head_nxt].q1 == ZERO_ROB) && (ent[head_nxt].q2 == ZERO_ROB);

  // A non-busy head with count != 0 is a hole left by rollback; it frees like a done entry.
  assign head_free = !ex_busy && (count != '0) && (!ent[head].busy || ent[head].done);
  assign head_ld   = !ex_busy && ent[head].busy && !ent[head].done && is_load(ent[head].op) && h_rdy
                     && ((h_addr != IO_ADDR) || (head_io_rob_id == ent[head].rob_id));
  assign head_st   = !ex_busy && ent[head].busy && is_store(ent[head].op) && h_rdy && ent[head].committed;
  assign head_act  = head_free || head_ld || head_st;

  assign win     = !head_act && ent[head].busy && is_store(ent[head].op) && h_rdy && !ent[head].committed
                   && ent[head_nxt].busy && is_load(ent[head_nxt].op) && l_rdy && !ent[head_nxt].done
                   && (l_addr != IO_ADDR);
  assign win_byp = win && !ex_busy && (h_addr[31:2] != l_addr[31:2]);
  assign win_fwd = win && is_word(ent[head].op) && is_word(ent[head_nxt].op) && (h_addr == l_addr);

  always_comb begin
    cm_hit = 1'b0;
    cm_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_flag && (commit_rob_id != ZERO_ROB) && ent[i].busy && !ent[i].committed
          && (ent[i].rob_id == commit_rob_id)) begin
        cm_hit = 1'b1;
        cm_idx = IDX_W'(i);
      end
    end
  end
  assign cm_is_store = is_store(ent[cm_idx].op);

  assign full_to_if = (count >= (IDX_W+1)'(DEPTH - FULL_WARN));
  assign io_rob_id  = (ent[head].busy && (h_addr == IO_ADDR)) ? ent[head].rob_id : '0;

  always_ff @(posedge clk) begin
    if (rst || (rdy && rollback && !store_tail_vld)) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      store_tail     <= '0;
      store_tail_vld <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      ex_ena     <= 1'b0;
      ex_op      <= OP_NOP;
      ex_addr    <= '0;
      ex_data    <= '0;
      ex_rob_id  <= '0;
      fwd_valid  <= 1'b0;
      fwd_rob_id <= '0;
      fwd_value  <= '0;
    end else if (rdy) begin
      ex_ena    <= 1'b0;
      fwd_valid <= 1'b0;
      if (rollback) begin
        // Committed stores survive; the queue is cut back to just after the youngest of them.
        tail  <= store_tail + IDX_W'(1);
        count <= {1'b0, rb_span} + (IDX_W+1)'(1);
        for (int i = 0; i < DEPTH; i++)
          if (!(ent[i].busy && ent[i].committed && is_store(ent[i].op))) ent[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent[i].busy && s1_hit[i]) begin
            ent[i].v1 <= s1_val[i];
            ent[i].q1 <= ZERO_ROB;
          end
          if (ent[i].busy && s2_hit[i]) begin
            ent[i].v2 <= s2_val[i];
            ent[i].q2 <= ZERO_ROB;
          end
        end
        if (head_st && (store_tail == head)) store_tail_vld <= 1'b0;
        if (cm_hit) begin
          ent[cm_idx].committed <= 1'b1;
          if (cm_is_store) begin
            store_tail     <= cm_idx;
            store_tail_vld <= 1'b1;
          end
        end
        if (head_ld || head_st) begin
          ex_ena    <= 1'b1;
          ex_op     <= ent[head].op;
          ex_addr   <= h_addr;
          ex_data   <= ent[head].v2;
          ex_rob_id <= ent[head].rob_id;
        end
        if (head_act) begin
          ent[head].busy      <= 1'b0;
          ent[head].done      <= 1'b0;
          ent[head].committed <= 1'b0;
          head                <= head_nxt;
        end
        if (win_byp) begin
          ex_ena    <= 1'b1;
          ex_op     <= ent[head_nxt].op;
          ex_addr   <= l_addr;
          ex_data   <= ent[head_nxt].v2;
          ex_rob_id <= ent[head_nxt].rob_id;
          ent[head_nxt].done <= 1'b1;
        end else if (win_fwd) begin
          fwd_valid  <= 1'b1;
          fwd_value  <= ent[head].v2;
          fwd_rob_id <= ent[head_nxt].rob_id;
          ent[head_nxt].done <= 1'b1;
        end
        if (dsp_ena) begin
          ent[tail] <= ins;
          tail      <= tail + IDX_W'(1);
        end
        count <= count + (IDX_W+1)'(dsp_ena) - (IDX_W+1)'(head_act);
      end
    end
  end

endmodule

// File: doc/lsb_fwd_queue.md
Name: lsb_fwd_queue

Overview:
Parametrised next-generation load/store buffer between dispatch, the ROB and the memory execute unit. In-order circular queue with generic CDB snooping over NUM_CDB channels and IO-port ordering via the ROB. Adds a two-entry issue window: a load directly behind a not-yet-committed store may bypass it, or take its value by store-to-load forwarding without a memory access. Uncommitted entries are flushed on rollback; committed stores are kept.

Parameters:
DEPTH, 16, entries; power of two, at least 4
IDX_W, $clog2(DEPTH), entry index width
ROB_W, 4, ROB id width; id 0 means "no dependency / invalid"
NUM_CDB, 3, number of snooped result buses
FULL_WARN, 2, full_to_if asserts when count >= DEPTH-FULL_WARN
IO_ADDR, 32'h30000, memory-mapped IO address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global stall; low freezes all state
dsp_ena  in  1  insert entry this cycle
dsp_op  in  OP_W  opcode (package enum)
dsp_v1, dsp_v2, dsp_imm  in  32 each  base, store data, offset
dsp_q1, dsp_q2  in  ROB_W each  operand tags
dsp_rob_id  in  ROB_W  entry tag
full_to_if  out  1  almost-full
ex_ena  out  1  request to memory unit
ex_op  out  OP_W  opcode
ex_addr  out  32  effective address
ex_data  out  32  store value
ex_rob_id  out  ROB_W  tag for the ls CDB
ex_busy  in  1  memory unit busy
fwd_valid  out  1  forwarded load result valid
fwd_rob_id  out  ROB_W  forwarded tag
fwd_value  out  32  forwarded value
commit_flag  in  1  ROB commits commit_rob_id
commit_rob_id  in  ROB_W
head_io_rob_id  in  ROB_W  ROB-head IO permission
io_rob_id  out  ROB_W  head tag if head address == IO_ADDR, else 0
cdb_valid  in  NUM_CDB  per-channel valid
cdb_rob_id  in  NUM_CDB*ROB_W  flattened tags
cdb_value  in  NUM_CDB*32  flattened values
rollback  in  1  flush speculative entries

Behaviour:
- Reset: head=tail=0, count=0, all busy/committed/done=0, store_tail invalid. ex_ena, fwd_valid=0; ex_*, fwd_* data=0.
- rdy low: no state change. Outputs hold, including ex_ena and fwd_valid.
- ex_ena and fwd_valid are single-cycle pulses, registered; latency is one cycle from the decision.
- Per entry: busy, op, v1, v2, q1, q2, imm, rob_id, committed, done. Address = v1+imm, wrapping mod 2^32. An entry is ready when q1==0 and q2==0.
- Insert at tail when dsp_ena. Operand tags are matched against all CDB channels in the same cycle; on a hit the entry stores value and q=0. Among multiple hits, the lowest channel wins.
- Snoop: every busy entry captures any matching channel each cycle.
- Commit: the busy, uncommitted entry with rob_id==commit_rob_id sets committed. If that entry is a store, store_tail takes its index.
- Head action (priority 1), requires ex_busy=0:
  - Head done: free it; no issue.
  - Ready load: issue if address!=IO_ADDR or head_io_rob_id==rob_id.
  - Ready committed store: issue. If store_tail==head, store_tail becomes invalid.
- Window action (priority 2), only if no head action this cycle. Applies when the head is a ready, uncommitted store S and head+1 is a ready, non-done load L with address!=IO_ADDR:
  - addr[31:2] differ: L issues to ex (needs ex_busy=0); L.done=1.
  - S is SW, L is LW, full addresses equal: fwd_valid=1, fwd_value=S.v2, fwd_rob_id=L.rob_id; L.done=1. ex is not used.
  - Otherwise: L waits.
- At most one of ex_ena/fwd_valid per cycle. Head advances by at most one per cycle.
- count = count + insert - free. A forwarded or bypassed load still occupies its slot until freed at the head.
- Full: full_to_if is the only backpressure. Insert into a full queue is illegal; the bench asserts on it.
- Rollback:
  - store_tail invalid: same as reset.
  - Otherwise: tail=store_tail+1 (wraps), count recomputed from head/store_tail; clears busy on every entry except committed stores. No issue that cycle.
- Wrap-around: all index increments are mod DEPTH. Head+1 is evaluated mod DEPTH.

Decomposition:
- Package lsb_pkg: opcode enum, is_load/is_store/is_word functions, ZERO_ROB, IO_ADDR default, entry struct.
- Sub-module cdb_match: parametrised NUM_CDB tag matcher returning hit and value. Instantiated twice for dispatch bypass and once per entry operand.

Test Plan:
- Reset, then LW with q1=0, v1=0x100, imm=4, ex_busy=0 -> ex_ena next cycle, ex_addr=0x104.
- SB addr 0x200 uncommitted at head, LW addr 0x300 behind -> LW issues first. Commit SB -> SB issues next; then head frees done LW; count returns to 0.
- SW addr 0x40, data 0xDEADBEEF uncommitted, LW 0x40 behind -> fwd_valid=1, fwd_value=0xDEADBEEF, fwd_rob_id=LW tag, ex_ena stays 0.
- SB 0x41, LW 0x40 -> no forward or issue until SB is committed and written.
- Dispatch with q1=5 while cdb channel 2 carries rob 5 = 0x10 -> entry stores v1=0x10, q1=0. LW at IO_ADDR waits until head_io_rob_id matches.
- Rollback with committed SW at index DEPTH-1, head=DEPTH-2 -> tail=0, count=2; uncommitted entries are gone.
